sccb_cfg_seq: RTL



---
 rtl/sccb_cfg_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sccb_cfg_seq.sv
// sccb_cfg_seq: table-driven SCCB register writer (3-byte writes, ms delays, end marker); optional NACK retry via `define NACK_RETRY_EN
module sccb_cfg_seq #(
    parameter int         CLK_FREQ    = 100_000_000,
    parameter logic [7:0] SLAVE_ADDR  = 8'h42,
    parameter int         ROM_AW      = 8,
    parameter int         MAX_RETRY   = 3,
    parameter int         TIMEOUT_CYC = 2_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              i2c_start,
    output logic              i2c_stop,
    output logic [7:0]        i2c_wr_data,
    input  logic [1:0]        i2c_ack,
    input  logic [3:0]        i2c_state,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ROM_AW-1:0] entry_cnt
);
    localparam int MS_CYC = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int CW = $clog2(MS_CYC + 1);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [3:0] {IDLE, FETCH, DECODE, START, XFER, WAIT_IDLE, DELAY, DONE, ABORT} state_t;

    state_t        state;
    logic [1:0]    byte_idx;
    logic [7:0]    reg_q;
    logic [7:0]    val_q;
    logic [7:0]    ms_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [WW-1:0] wd_cnt;
    logic          wrapped;
    logic          wd_hit;

`ifdef NACK_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [RW-1:0] retry_cnt;
    logic          nack_seen;
`else
    logic unused_ack;
    assign unused_ack = i2c_ack[0];
`endif

    // Bus-facing outputs decode straight from state so the next byte is stable before each ack tick
    assign i2c_start   = (state == START);
    assign i2c_stop    = (state == ABORT) || (state == XFER && byte_idx == 2'd2);
    assign i2c_wr_data = (state == START) ? {SLAVE_ADDR[7:1], 1'b0} :
                         (state != XFER)  ? 8'h00 :
                         (byte_idx == 2'd0) ? reg_q :
                         (byte_idx == 2'd1) ? val_q : 8'h00;

    // Watchdog expiry takes priority over any ack tick in the same cycle
    assign wd_hit = (state == START || state == XFER || state == WAIT_IDLE) &&
                    wd_cnt == WW'(TIMEOUT_CYC - 1);

    // Sequencer: walks the table, runs each write or delay, and reports done/err
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            entry_cnt <= '0;
            byte_idx  <= 2'd0;
            reg_q     <= 8'h00;
            val_q     <= 8'h00;
            ms_cnt    <= 8'h00;
            cyc_cnt   <= '0;
            wd_cnt    <= '0;
            wrapped   <= 1'b0;
`ifdef NACK_RETRY_EN
            retry_cnt <= '0;
            nack_seen <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (wd_hit) begin
                err   <= 1'b1;
                busy  <= 1'b0;
                state <= ABORT;
            end else begin
                case (state)
                    IDLE: if (go) begin
                        err       <= 1'b0;
                        entry_cnt <= '0;
                        rom_addr  <= '0;
                        wrapped   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                    FETCH: if (wrapped) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        state <= DECODE;
                    end
                    DECODE: if (rom_data == 16'hFFFF) begin
                        state <= DONE;
                    end else if (rom_data[15:8] == 8'hF0) begin
                        ms_cnt  <= rom_data[7:0];
                        cyc_cnt <= '0;
                        state   <= DELAY;
                    end else begin
                        reg_q     <= rom_data[15:8];
                        val_q     <= rom_data[7:0];
                        byte_idx  <= 2'd0;
                        wd_cnt    <= '0;
`ifdef NACK_RETRY_EN
                        retry_cnt <= '0;
                        nack_seen <= 1'b0;
`endif
                        state     <= START;
                    end
                    START: begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (i2c_state != 4'd0) state <= XFER;
                    end
                    XFER: begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (i2c_ack[1]) begin
                            byte_idx <= byte_idx + 1'b1;
`ifdef NACK_RETRY_EN
                            nack_seen <= nack_seen | ~i2c_ack[0];
`endif
                            if (byte_idx == 2'd2) state <= WAIT_IDLE;
                        end
                    end
                    WAIT_IDLE: begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (i2c_state == 4'd0) begin
`ifdef NACK_RETRY_EN
                            if (nack_seen && retry_cnt < RW'(MAX_RETRY)) begin
                                retry_cnt <= retry_cnt + 1'b1;
                                nack_seen <= 1'b0;
                                byte_idx  <= 2'd0;
                                wd_cnt    <= '0;
                                state     <= START;
                            end else if (nack_seen) begin
                                err   <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                entry_cnt <= entry_cnt + 1'b1;
                                wrapped   <= &rom_addr;
                                rom_addr  <= rom_addr + 1'b1;
                                state     <= FETCH;
                            end
`else
                            entry_cnt <= entry_cnt + 1'b1;
                            wrapped   <= &rom_addr;
                            rom_addr  <= rom_addr + 1'b1;
                            state     <= FETCH;
`endif
                        end
                    end
                    DELAY: if (ms_cnt == 8'h00) begin
                        wrapped  <= &rom_addr;
                        rom_addr <= rom_addr + 1'b1;
                        state    <= FETCH;
                    end else if (cyc_cnt == CW'(MS_CYC - 1)) begin
                        cyc_cnt <= '0;
                        ms_cnt  <= ms_cnt - 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                    DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    ABORT: if (i2c_state == 4'd0) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
